lut_arbiter: RTL and testbench

Shares one 16-entry function-table unit (4-bit select into a 16-bit truth table, mux16x1 semantics) between N_REQ requesters. It arbitrates round-robin, evaluates one lookup per cycle, and returns the registered result with the winner's ID. The truth table is loaded by a bit-serial configuration sequence. The block sits between the requesting logic blocks and the shared mux-tree function generator and replaces per-requester mux16x1 copies.

---
 rtl/lut_arbiter_if.sv | 45 ++++
 rtl/lut_arbiter.sv | 159 +++++++++++++++
 tb/tb_lut_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_arbiter_if.sv
// lut_arbiter_if
//   Bundles the requester-side handshake and the serial configuration port
//   of the shared 16-entry function table.
//
//   master : requesting logic / configuration source
//            drives req, sel, cfg_start, cfg_bit
//            observes ack, rsp_valid, rsp_id, rsp_y, cfg_busy, cfg_done
//   slave  : lut_arbiter (the shared table unit)
//
//   req       [N_REQ]    per-requester request level
//   sel       [4*N_REQ]  per-requester table index, requester i on sel[4i+3:4i]
//   ack       [N_REQ]    one-hot completion strobe
//   rsp_valid            rsp_id / rsp_y valid this cycle
//   rsp_id    [ID_W]     requester served
//   rsp_y                table bit selected by the winner
//   cfg_start            pulse: begin a 16-bit serial table load
//   cfg_bit              serial table data, bit 15 first
//   cfg_busy             high while a load is in progress
//   cfg_done             one-cycle pulse when the new table is committed
interface lut_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] sel;
  logic [N_REQ-1:0]   ack;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_y;
  logic               cfg_start;
  logic               cfg_bit;
  logic               cfg_busy;
  logic               cfg_done;

  modport master (
    output req, sel, cfg_start, cfg_bit,
    input  ack, rsp_valid, rsp_id, rsp_y, cfg_busy, cfg_done
  );

  modport slave (
    input  req, sel, cfg_start, cfg_bit,
    output ack, rsp_valid, rsp_id, rsp_y, cfg_busy, cfg_done
  );
endinterface

// File: rtl/lut_arbiter.sv
// lut_arbiter
//   One 16-entry function table (4-bit index into a 16-bit truth table)
//   shared round-robin between N_REQ requesters. One lookup per cycle; the
//   result is registered and returned with the winner's ID. The table is
//   reloaded through a bit-serial port, during which no grants are issued.
//
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : lut_arbiter_if.slave (request/response and configuration)
module lut_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  lut_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {
    SERVE = 1'b0,
    LOAD  = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [15:0]        lut_q,       lut_d;
  // Only 15 bits are kept: the 16th bit goes straight from cfg_bit into the
  // table on the commit edge.
  logic [14:0]        shadow_q,    shadow_d;
  logic [3:0]         cnt_q,       cnt_d;
  logic [ID_W-1:0]    ptr_q,       ptr_d;
  logic [N_REQ-1:0]   ack_q,       ack_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
  logic               rsp_y_q,     rsp_y_d;
  logic               cfg_done_q,  cfg_done_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W:0]      cand;
  logic [3:0]         grant_sel;

  // Round-robin search: first requester with req high, starting one past the
  // last winner and wrapping modulo N_REQ. cand carries one extra bit so the
  // sum ptr+off (< 2*N_REQ) never overflows before the wrap correction.
  always_comb begin : rr_search
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!grant_found && bus.req[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // Winner's index, picked with constant part-selects.
  always_comb begin : sel_mux
    grant_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_sel = bus.sel[4*i +: 4];
      end
    end
  end

  always_comb begin : next_state
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    lut_d       = lut_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    cfg_done_d  = 1'b0;

    unique case (state_q)
      SERVE: begin
        if (grant_found) begin
          ack_d[grant_id] = 1'b1;
          rsp_valid_d     = 1'b1;
          rsp_id_d        = grant_id;
          rsp_y_d         = lut_q[grant_sel];
          ptr_d           = grant_id;
        end
        // The cycle carrying cfg_start still arbitrates on the old table.
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        // Grants are suppressed and the pointer holds; requesters keep req
        // asserted and are picked up once the new table is in place.
        shadow_d = {shadow_q[13:0], bus.cfg_bit};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          lut_d      = {shadow_q, bus.cfg_bit};
          state_d    = SERVE;
          cfg_done_d = 1'b1;
        end
      end

      default: begin
        state_d = SERVE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      // NOTE: the table is a handful of flops rather than a RAM, so it is
      // cleared by reset like every other register; a mid-load reset leaves
      // an all-zero table, never a half-loaded one.
      lut_q       <= '0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      // Pointer starts at the last requester so requester 0 wins first.
      ptr_q       <= ID_W'(N_REQ - 1);
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge
      // value of every other flop regardless of statement order.
      state_q     <= state_d;
      lut_q       <= lut_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.cfg_busy  = (state_q == LOAD);

endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter
//   Directed and randomized stimulus for lut_arbiter. A behavioural model
//   (round-robin search by modulo arithmetic, table built from a queue of
//   received bits) pushes expected responses into a scoreboard queue; a
//   separate monitor pops and compares whenever the DUT presents rsp_valid,
//   and checks cfg_busy / cfg_done every cycle.
module tb_lut_arbiter;
  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_arbiter_if #(.N_REQ(N)) bus ();
  lut_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    bit y;
    int cyc;
  } rsp_t;
  rsp_t rsp_q[$];

  // reference model state
  bit [15:0]  m_lut;
  int         m_ptr;
  bit         m_loading;
  bit         m_bits[$];
  bit [N-1:0] m_ack_now;
  bit         exp_busy;
  bit         exp_done;

  // driven stimulus
  bit [N-1:0]   d_req;
  bit [4*N-1:0] d_sel;
  bit           d_start;
  bit           d_bit;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit [4*N-1:0] sel1(int i, bit [3:0] v);
    bit [4*N-1:0] s = '0;
    s[4*i +: 4] = v;
    return s;
  endfunction

  task automatic apply();
    bus.req       = d_req;
    bus.sel       = d_sel;
    bus.cfg_start = d_start;
    bus.cfg_bit   = d_bit;
  endtask

  task automatic model_reset();
    m_lut     = '0;
    m_ptr     = N - 1;
    m_loading = 1'b0;
    m_bits.delete();
    m_ack_now = '0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    rsp_q.delete();
  endtask

  // Predicts what the DUT shows after the next rising edge, given d_*.
  task automatic model_step();
    bit [N-1:0] granted = '0;
    bit         done    = 1'b0;
    int         w       = -1;
    if (m_loading) begin
      m_bits.push_back(d_bit);
      if (m_bits.size() == 16) begin
        for (int k = 0; k < 16; k++) m_lut[15-k] = m_bits[k];
        m_bits.delete();
        m_loading = 1'b0;
        done      = 1'b1;
      end
    end else begin
      for (int j = 1; j <= N; j++) begin
        int c = (m_ptr + j) % N;
        if (w < 0 && d_req[c]) w = c;
      end
      if (w >= 0) begin
        granted[w] = 1'b1;
        rsp_q.push_back('{id: w, y: m_lut[d_sel[4*w +: 4]], cyc: cyc + 1});
        m_ptr = w;
      end
      if (d_start) m_loading = 1'b1;
    end
    m_ack_now = granted;
    exp_busy  = m_loading;
    exp_done  = done;
  endtask

  task automatic drive(bit [N-1:0] r, bit [4*N-1:0] s, bit st, bit b);
    @(negedge clk);
    d_req   = r;
    d_sel   = s;
    d_start = st;
    d_bit   = b;
    apply();
    model_step();
  endtask

  task automatic do_reset(int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_busy", bus.cfg_busy, 0);
    for (int k = 0; k < ncyc; k++) begin
      d_req   = N'($urandom);
      d_sel   = (4*N)'($urandom);
      d_start = 1'($urandom);
      d_bit   = 1'($urandom);
      apply();
      @(posedge clk);
      #1;
      check("rst_ack",       bus.ack,       0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id",    bus.rsp_id,    0);
      check("rst_rsp_y",     bus.rsp_y,     0);
      check("rst_cfg_busy",  bus.cfg_busy,  0);
      check("rst_cfg_done",  bus.cfg_done,  0);
      @(negedge clk);
    end
    rst_n   = 1'b1;
    d_req   = '0;
    d_sel   = '0;
    d_start = 1'b0;
    d_bit   = 1'b0;
    apply();
    model_step();
  endtask

  // cfg_start cycle followed by 16 bit cycles; req0 (index sv) is raised from
  // bit cycle stall_at onward and held until its ack when stall_at >= 0.
  task automatic load_table(bit [15:0] val, int stall_at, bit [3:0] sv);
    drive('0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      bit [N-1:0] r = (stall_at >= 0 && k >= stall_at) ? N'(1) : '0;
      drive(r, sel1(0, sv), 1'b0, val[15-k]);
    end
    if (stall_at >= 0) begin
      for (int w = 0; w < 4 && !m_ack_now[0]; w++) drive(N'(1), sel1(0, sv), 1'b0, 1'b0);
      drive('0, '0, 1'b0, 1'b0);
    end
  endtask

  // monitor / scoreboard
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        check("cfg_busy", bus.cfg_busy, exp_busy);
        check("cfg_done", bus.cfg_done, exp_done);
        if (bus.rsp_valid) begin
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected_valid", bus.rsp_valid, 0);
          end else begin
            e = rsp_q.pop_front();
            check("rsp_cycle", cyc,        e.cyc);
            check("rsp_id",    bus.rsp_id, e.id);
            check("rsp_y",     bus.rsp_y,  e.y);
            check("rsp_ack",   bus.ack,    1 << e.id);
          end
        end else begin
          check("ack_idle", bus.ack, 0);
          if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
            check("rsp_missing", bus.rsp_valid, 1);
            void'(rsp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    d_req = '0; d_sel = '0; d_start = 1'b0; d_bit = 1'b0;
    apply();
    model_reset();
    do_reset(3);

    // lookup right after reset: table is all zero
    drive(N'(1), sel1(0, 4'($urandom)), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);

    // single request against 16'h0020
    load_table(16'h0020, -1, 4'd0);
    drive(4'b0100, sel1(2, 4'd5), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    drive(4'b0100, sel1(2, 4'd4), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);

    // round-robin, all requesters continuous
    for (int k = 0; k < 8; k++) drive(4'b1111, 16'h5A3C, 1'b0, 1'b0);
    // partial pattern, then requester 0 joins
    for (int k = 0; k < 6; k++) drive(4'b1010, 16'h5A3C, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) drive(4'b1011, 16'h5A3C, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);

    // serial load with both end bits set
    load_table(16'h8001, -1, 4'd0);
    drive(4'b0010, sel1(1, 4'd15), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    drive(4'b0010, sel1(1, 4'd0), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    drive(4'b0010, sel1(1, 4'd14), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);

    // request raised in the 3rd load cycle waits for the new table
    load_table(16'hA5C3, 2, 4'd6);
    load_table(16'h3C5A, 2, 4'd3);

    // reset in the middle of a load
    drive('0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive('0, '0, 1'b0, 1'b1);
    do_reset(2);
    drive(4'b1000, sel1(3, 4'($urandom)), 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    load_table(16'($urandom), -1, 4'd0);

    // randomized traffic honouring the hold-until-ack rule
    for (int t = 0; t < 500; t++) begin
      bit [N-1:0]   r = d_req;
      bit [4*N-1:0] s = d_sel;
      for (int i = 0; i < N; i++) begin
        if (!r[i] || m_ack_now[i]) begin
          r[i]        = ($urandom_range(0, 2) != 0);
          s[4*i +: 4] = 4'($urandom);
        end
      end
      drive(r, s, ($urandom_range(0, 39) == 0), 1'($urandom));
    end

    for (int k = 0; k < 20; k++) drive('0, '0, 1'b0, 1'($urandom));
    @(posedge clk);
    #2;
    check("scoreboard_drain", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
